// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared width default and serializer state encodings for the serial adder datapath
package serial_adder_pkg;
  localparam int DEF_WIDTH = 5;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b11
  } state_e;
endpackage

// File: rtl/operand_serializer.sv
// operand_serializer: accepts operand words and emits them LSB-first, one framed bit pair per cycle
module operand_serializer
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             shift_en,
  output logic             a,
  output logic             b,
  output logic             bit_valid,
  output logic             first,
  output logic             last
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] act_a_q, act_a_d, act_b_q, act_b_d;
  logic [WIDTH-1:0] pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic act_full, pend_full, accept, consume;
  assign act_full  = state_q != EMPTY;
  assign pend_full = state_q == FULL;
  assign in_ready  = !pend_full;
  assign accept    = in_valid && in_ready;
  assign consume   = shift_en && act_full;
  assign bit_valid = act_full;
  assign a         = act_a_q[0] & act_full;
  assign b         = act_b_q[0] & act_full;
  assign first     = act_full && idx_q == '0;
  assign last      = act_full && idx_q == LAST_IDX;
  // Slot state and data: shift on consume, refill active from input or pending at word boundaries
  always_comb begin
    state_d  = state_q;
    act_a_d  = consume ? act_a_q >> 1 : act_a_q;
    act_b_d  = consume ? act_b_q >> 1 : act_b_q;
    idx_d    = consume ? (last ? '0 : idx_q + IW'(1)) : idx_q;
    pend_a_d = pend_a_q;
    pend_b_d = pend_b_q;
    case (state_q)
      EMPTY: if (accept) begin
        act_a_d = in_a;
        act_b_d = in_b;
        state_d = SHIFT;
      end
      SHIFT: if (consume && last) begin
        if (accept) begin
          act_a_d = in_a;
          act_b_d = in_b;
        end else state_d = EMPTY;
      end else if (accept) begin
        pend_a_d = in_a;
        pend_b_d = in_b;
        state_d  = FULL;
      end
      FULL: if (consume && last) begin
        act_a_d = pend_a_q;
        act_b_d = pend_b_q;
        state_d = SHIFT;
      end
      default: state_d = EMPTY;
    endcase
  end
  // State register; reset abandons any word in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      act_a_q  <= '0;
      act_b_q  <= '0;
      pend_a_q <= '0;
      pend_b_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      act_a_q  <= act_a_d;
      act_b_q  <= act_b_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      idx_q    <= idx_d;
    end
  end
endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: vector, corner-case and randomized checks of the operand serializer
module tb_operand_serializer;
  localparam int W = 5;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  logic in_valid = 0, shift_en = 0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic in_ready, a, b, bit_valid, first, last;
  logic v1 = 0, s1 = 0, ia1 = 0, ib1 = 0;
  logic r1, oa1, ob1, bv1, f1, l1;
  operand_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .shift_en(shift_en),
    .a(a), .b(b), .bit_valid(bit_valid), .first(first), .last(last)
  );
  operand_serializer #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
    .in_a(ia1), .in_b(ib1), .shift_en(s1),
    .a(oa1), .b(ob1), .bit_valid(bv1), .first(f1), .last(l1)
  );
  int asserts = 0, fails = 0;
  typedef struct {
    logic [W-1:0] a, b;
  } word_t;
  word_t q[$];
  int p = 0;
  typedef struct {
    logic [W-1:0] a, b, sa, sb;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic mcheck();
    logic v;
    v = q.size() > 0;
    chk("m_in_ready", in_ready, q.size() < 2);
    chk("m_bit_valid", bit_valid, v);
    chk("m_a", a, v ? q[0].a[p] : 1'b0);
    chk("m_b", b, v ? q[0].b[p] : 1'b0);
    chk("m_first", first, v && p == 0);
    chk("m_last", last, v && p == W - 1);
  endtask
  task automatic cycle();
    logic acc;
    mcheck();
    acc = in_valid && q.size() < 2;
    if (shift_en && q.size() > 0) begin
      p++;
      if (p == W) begin
        void'(q.pop_front());
        p = 0;
      end
    end
    if (acc) q.push_back('{in_a, in_b});
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [W-1:0] wa, input logic [W-1:0] wb);
    in_valid = 1;
    in_a = wa;
    in_b = wb;
  endtask
  task automatic drain();
    in_valid = 0;
    shift_en = 1;
    for (int i = 0; i < 2 * W + 2; i++) cycle();
    chk("drain_idle", bit_valid, 0);
  endtask
  logic [1:0] w1_in[3];
  int n;
  initial begin
    tbl[0] = '{5'b10101, 5'b10011, 5'b10101, 5'b11001};
    tbl[1] = '{5'b00001, 5'b11111, 5'b10000, 5'b11111};
    tbl[2] = '{5'b11000, 5'b00110, 5'b00011, 5'b01100};
    tbl[3] = '{5'b01110, 5'b10000, 5'b01110, 5'b00001};
    w1_in[0] = 2'b10;
    w1_in[1] = 2'b01;
    w1_in[2] = 2'b11;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_first", first, 0);
    #21 reset = 1;
    @(posedge clk);
    #1;
    shift_en = 1;
    for (int v = 0; v < 4; v++) begin
      offer(tbl[v].a, tbl[v].b);
      cycle();
      in_valid = 0;
      for (int c = 0; c < W; c++) begin
        chk("vec_a", a, tbl[v].sa[W-1-c]);
        chk("vec_b", b, tbl[v].sb[W-1-c]);
        chk("vec_first", first, c == 0);
        chk("vec_last", last, c == W - 1);
        cycle();
      end
      chk("vec_idle", bit_valid, 0);
      cycle();
    end
    offer(5'b10101, 5'b10011);
    cycle();
    in_valid = 0;
    cycle();
    offer(5'b00001, 5'b11111);
    chk("b2b_ready_before", in_ready, 1);
    cycle();
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("b2b_ready_low", in_ready, 0);
      cycle();
    end
    chk("b2b_first", first, 1);
    chk("b2b_a", a, 1);
    chk("b2b_b", b, 1);
    chk("b2b_ready_back", in_ready, 1);
    drain();
    offer(5'b10101, 5'b10011);
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    shift_en = 0;
    for (int c = 0; c < 3; c++) begin
      chk("stall_a", a, 1);
      chk("stall_b", b, 0);
      chk("stall_first", first, 0);
      chk("stall_last", last, 0);
      cycle();
    end
    shift_en = 1;
    n = 5;
    while (bit_valid && n < 20) begin
      n++;
      cycle();
    end
    chk("stall_duration", n, 8);
    offer(5'b10101, 5'b10011);
    cycle();
    in_valid = 0;
    for (int c = 0; c < W - 1; c++) cycle();
    offer(5'b01110, 5'b10000);
    chk("sim_ready", in_ready, 1);
    chk("sim_last", last, 1);
    cycle();
    in_valid = 0;
    chk("sim_ready_after", in_ready, 1);
    chk("sim_no_gap", bit_valid, 1);
    chk("sim_first", first, 1);
    drain();
    offer(5'b10101, 5'b10011);
    cycle();
    cycle();
    cycle();
    #2 reset = 0;
    #1;
    chk("rstm_a", a, 0);
    chk("rstm_b", b, 0);
    chk("rstm_bv", bit_valid, 0);
    chk("rstm_first", first, 0);
    chk("rstm_last", last, 0);
    chk("rstm_ready", in_ready, 1);
    q.delete();
    p = 0;
    @(posedge clk);
    #1;
    chk("rstm_hs_discard", bit_valid, 0);
    in_valid = 0;
    reset = 1;
    for (int c = 0; c < 3; c++) cycle();
    s1 = 1;
    v1 = 1;
    for (int i = 0; i < 3; i++) begin
      ia1 = w1_in[i][1];
      ib1 = w1_in[i][0];
      @(posedge clk);
      #1;
      chk("w1_ready", r1, 1);
      chk("w1_bv", bv1, 1);
      chk("w1_first", f1, 1);
      chk("w1_last", l1, 1);
      chk("w1_a", oa1, w1_in[i][1]);
      chk("w1_b", ob1, w1_in[i][0]);
    end
    v1 = 0;
    @(posedge clk);
    #1;
    chk("w1_idle", bv1, 0);
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      shift_en = ($urandom % 4) != 0;
      in_a = W'($urandom);
      in_b = W'($urandom);
      cycle();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/operand_serializer.md
# operand_serializer

Upstream feeder for the Mealy serial adder. Accepts two WIDTH-bit operands per word over a valid/ready handshake and emits them LSB-first, one bit pair per cycle, on the adder's `a`/`b` inputs. Each word is framed with `first`/`last` strobes so the adder clears its carry at word boundaries without a reset pulse. A one-word holding slot allows back-to-back words with no idle cycle.

## Interface
- `WIDTH`, default 5: operand width in bits; legal range is WIDTH ≥ 1.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: upstream word present.
- `in_ready`  out  1: block can accept a word.
- `in_a`  in  WIDTH: operand A.
- `in_b`  in  WIDTH: operand B.
- `shift_en`  in  1: downstream consumes the current bit pair this cycle.
- `a`  out  1: current A bit, drives adder `a`.
- `b`  out  1: current B bit, drives adder `b`.
- `bit_valid`  out  1: `a`/`b` carry a real bit.
- `first`  out  1: current bit is bit 0; the adder uses carry-in = 0.
- `last`  out  1: current bit is bit WIDTH-1.

## Operation
- Storage:
  - Active slot: `act_a`, `act_b`, `act_full`, bit index `idx` of width max(1,$clog2(WIDTH)).
  - Pending slot: `pend_a`, `pend_b`, `pend_full`.
- Handshake and bit outputs:
  - `in_ready = !pend_full`. A word is accepted when `in_valid && in_ready` at a rising edge.
  - `bit_valid = act_full`. `a = act_a[0] & act_full`, `b = act_b[0] & act_full`.
  - `first = act_full && idx==0`. `last = act_full && idx==WIDTH-1`.
- `consume = shift_en && act_full`. On consume, `act_a`/`act_b` shift right by 1 and `idx` increments.
- When consume occurs with `last` high, the active slot empties or reloads; `idx` returns to 0.
- States, derived from {act_full, pend_full}:
  - EMPTY: accept loads the active slot directly → SHIFT.
  - SHIFT, no last-consume: accept loads the pending slot → FULL.
  - SHIFT, last-consume without accept → EMPTY.
  - SHIFT, last-consume with accept in the same cycle: the incoming word loads the active slot directly → stays SHIFT; `in_ready` stays 1.
  - FULL: no accept is possible (`in_ready`=0). Last-consume moves pending to active, clears `pend_full` → SHIFT.
- `shift_en` low holds all state; `a`, `b`, `first` and `last` are stable.
- `shift_en` high while EMPTY has no effect.
- Words are emitted in acceptance order; none are dropped or duplicated.
- WIDTH=1: `first` and `last` are high together on every valid bit.

## Timing
- Reset values (asynchronous, immediate on `reset` low):
  - Active slot cleared: `act_full`=0, `idx`=0.
  - Pending slot cleared: `pend_full`=0.
  - Outputs: `a`=`b`=`bit_valid`=`first`=`last`=0, `in_ready`=1.
- Handshakes presented while `reset` is low are discarded.
- Reset mid-word abandons the word. The first bit after reset release comes from a newly accepted word.
- Latency: a word accepted at edge k from EMPTY shows bit 0 (`first`=1) in the cycle following edge k.
- Throughput: one word per WIDTH cycles with `shift_en` held high; no bubble between words when the pending slot is full or an accept coincides with last-consume.
- All outputs are registered state or simple AND terms of it. There is no combinational path from `in_*` or `shift_en` to `a`, `b`, `bit_valid`, `first` or `last`.

## Structure
- Shared package `serial_adder_pkg`:
  - Default WIDTH constant (5), also used by the adder.
  - State encodings EMPTY/SHIFT/FULL, used for assertions and debug.
- Single module; no sub-module is required. The two slots are plain registers inside it.

## Test plan
- Reset: drive `reset` low during bit 2 of a word → all outputs 0 and `in_ready`=1 in the same cycle. After release with no new word, `bit_valid` stays 0.
- Single word, WIDTH=5, A=10101, B=10011, `shift_en`=1 → over the 5 cycles after accept:
  - `a` = 1,0,1,0,1 and `b` = 1,1,0,0,1.
  - `first` high in cycle 1 only, `last` high in cycle 5 only.
  - `bit_valid`=0 in cycle 6.
- Back-to-back: offer A=00001, B=11111 during bit 1 of the previous word → accepted to pending, `in_ready`=0 until the previous `last` is consumed. Bit 0 of the new word (`a`=1, `b`=1, `first`=1) appears in the very next cycle.
- Stall: deassert `shift_en` for 3 cycles at bit 2 of A=10101 → `a`=1, `b`=0, `idx`=2 held. The remaining bits resume unchanged and total word duration is 8 cycles.
- Simultaneous: pending empty, `in_valid`=1 in the cycle `last` is consumed → the new word enters the active slot directly, `in_ready` never drops, and `bit_valid` has no gap.
- WIDTH=1: three words 1/0, 0/1, 1/1 back-to-back → `first`=`last`=1 on each of 3 consecutive cycles, with `a`/`b` = 1/0, 0/1, 1/1.
